// File: rtl/counter_period_ctl.sv
// Period/duty control stage for counter_last: buffers one pending period/duty setting
// and commits it only at a counter wrap; drives a registered PWM from cnt and the active duty.
module counter_period_ctl #(
    parameter int unsigned      WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_MAX = {WIDTH{1'b1}},
    parameter logic [WIDTH:0]   RST_DTY = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] cnt,
    input  logic             pls,
    input  logic             cfg_vld,
    output logic             cfg_rdy,
    input  logic [WIDTH-1:0] cfg_max,
    input  logic [WIDTH:0]   cfg_dty,
    output logic [WIDTH-1:0] max,
    output logic [WIDTH:0]   dty,
    output logic             pwm,
    output logic             upd
);

    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_PENDING = 1'b1
    } buf_state_e;

    buf_state_e       r_state;
    buf_state_e       w_state_nxt;
    logic             w_xfer;
    logic             w_apply;
    logic             w_pwm_nxt;

    logic [WIDTH-1:0] r_max;
    logic [WIDTH:0]   r_dty;
    logic [WIDTH-1:0] r_pnd_max;
    logic [WIDTH:0]   r_pnd_dty;
    logic             r_pwm;
    logic             r_upd;

    // Ready depends only on the buffer state, so a transfer and a commit never share a cycle.
    assign cfg_rdy   = (r_state == ST_EMPTY);
    assign w_xfer    = cfg_vld & cfg_rdy;
    assign w_apply   = ena & pls & (r_state == ST_PENDING);
    assign w_pwm_nxt = ({1'b0, cnt} < r_dty);

    always_comb begin
        // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY:   if (w_xfer)  w_state_nxt = ST_PENDING;
            ST_PENDING: if (w_apply) w_state_nxt = ST_EMPTY;
            default:                 w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_EMPTY;
            r_max     <= RST_MAX;
            r_dty     <= RST_DTY;
            r_pnd_max <= '0;
            r_pnd_dty <= '0;
            r_pwm     <= 1'b0;
            r_upd     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                r_pnd_max <= cfg_max;
                r_pnd_dty <= cfg_dty;
            end
            // Commit on the wrap edge so the next period runs entirely on the new values.
            if (w_apply) begin
                r_max <= r_pnd_max;
                r_dty <= r_pnd_dty;
            end
            r_upd <= w_apply;
            r_pwm <= w_pwm_nxt;
        end
    end

    assign max = r_max;
    assign dty = r_dty;
    assign pwm = r_pwm;
    assign upd = r_upd;

endmodule

// File: tb/tb_counter_period_ctl.sv
// Bench for counter_period_ctl with a behavioural counter_last; commits are scoreboarded
// against a queue of expected (max, dty) pairs, popped by a monitor on every upd pulse.
module tb_counter_period_ctl;

    localparam int WIDTH = 4;

    typedef struct {
        logic [WIDTH-1:0] m;
        logic [WIDTH:0]   d;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             ena;
    logic [WIDTH-1:0] cnt;
    logic             pls;
    logic             cfg_vld;
    logic             cfg_rdy;
    logic [WIDTH-1:0] cfg_max;
    logic [WIDTH:0]   cfg_dty;
    logic [WIDTH-1:0] max;
    logic [WIDTH:0]   dty;
    logic             pwm;
    logic             upd;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    logic prev_upd = 1'b0;

    counter_period_ctl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .ena(ena), .cnt(cnt), .pls(pls),
        .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy), .cfg_max(cfg_max), .cfg_dty(cfg_dty),
        .max(max), .dty(dty), .pwm(pwm), .upd(upd)
    );

    always #5 clk = ~clk;

    // Stand-in for counter_last: counts 0..max while enabled, pls marks cnt == max.
    always @(posedge clk) begin
        if (rst)           cnt <= '0;
        else if (ena)      cnt <= (cnt == max) ? '0 : 4'(cnt + 4'd1);
    end
    assign pls = (cnt == max);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [WIDTH-1:0] m, input logic [WIDTH:0] d);
        exp_t e;
        e.m = m;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [WIDTH-1:0] m, input logic [WIDTH:0] d);
        cfg_vld = 1'b1;
        cfg_max = m;
        cfg_dty = d;
        tick();
        cfg_vld = 1'b0;
    endtask

    task automatic wait_cnt(input logic [WIDTH-1:0] v, input int budget);
        int n = 0;
        while (cnt != v && n < budget) begin
            tick();
            n++;
        end
        check("wait_cnt", 32'(cnt), 32'(v));
    endtask

    task automatic wait_upd(input int budget);
        int n = 0;
        while (upd !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("wait_upd", 32'(upd), 1);
    endtask

    // Monitor: every commit must match the next queued expectation and land on cnt == 0.
    always @(negedge clk) begin
        if (!rst && upd) begin
            check("upd_single", 32'(prev_upd), 0);
            if (exp_q.size() == 0) begin
                check("upd_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("commit_max", 32'(max), 32'(e.m));
                check("commit_dty", 32'(dty), 32'(e.d));
                check("commit_cnt", 32'(cnt), 0);
            end
        end
        prev_upd = rst ? 1'b0 : upd;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] pc;
        rst     = 1'b1;
        ena     = 1'b0;
        cfg_vld = 1'b0;
        cfg_max = '0;
        cfg_dty = '0;

        // Reset defaults
        repeat (4) tick();
        rst = 1'b0;
        tick();
        check("rst_max", 32'(max), 15);
        check("rst_dty", 32'(dty), 0);
        check("rst_pwm", 32'(pwm), 0);
        check("rst_upd", 32'(upd), 0);
        check("rst_rdy", 32'(cfg_rdy), 1);
        ena = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            check("rst_pwm_run", 32'(pwm), 0);
        end

        // Aligned commit: transfer at cnt=3, commit exactly at the 15->0 wrap
        wait_cnt(4'd3, 20);
        check("xfer_rdy_before", 32'(cfg_rdy), 1);
        push(4'd5, 5'd2);
        send(4'd5, 5'd2);
        check("xfer_rdy_after", 32'(cfg_rdy), 0);
        check("xfer_max_hold", 32'(max), 15);
        wait_cnt(4'd15, 20);
        check("prewrap_upd", 32'(upd), 0);
        check("prewrap_max", 32'(max), 15);
        tick();
        check("wrap_upd", 32'(upd), 1);
        check("wrap_rdy", 32'(cfg_rdy), 1);
        for (int i = 0; i < 12; i++) begin
            pc = cnt;
            tick();
            check("pwm_d2", 32'(pwm), (pc < 4'd2) ? 1 : 0);
        end

        // Back-pressure: second request held while PENDING, accepted after the commit
        push(4'd4, 5'd1);
        send(4'd4, 5'd1);
        push(4'd7, 5'd3);
        cfg_vld = 1'b1;
        cfg_max = 4'd7;
        cfg_dty = 5'd3;
        check("bp_rdy", 32'(cfg_rdy), 0);
        tick();
        check("bp_rdy_hold", 32'(cfg_rdy), 0);
        check("bp_max_hold", 32'(max), 5);
        wait_upd(20);
        check("bp_rdy_back", 32'(cfg_rdy), 1);
        check("bp_max_first", 32'(max), 4);
        tick();
        cfg_vld = 1'b0;
        check("bp_taken", 32'(cfg_rdy), 0);
        wait_upd(20);
        check("bp_max_second", 32'(max), 7);

        // Stall: pending config parked at cnt == max with ena = 0
        push(4'd5, 5'd3);
        send(4'd5, 5'd3);
        wait_cnt(4'd7, 20);
        ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_upd", 32'(upd), 0);
            check("stall_max", 32'(max), 7);
            check("stall_pwm", 32'(pwm), 0);
        end
        ena = 1'b1;
        tick();
        check("stall_release_upd", 32'(upd), 1);
        check("stall_release_max", 32'(max), 5);

        // Duty bounds with max = 3
        push(4'd3, 5'd0);
        send(4'd3, 5'd0);
        wait_upd(20);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("duty0_pwm", 32'(pwm), 0);
        end
        push(4'd3, 5'd4);
        send(4'd3, 5'd4);
        wait_upd(20);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("duty4_pwm", 32'(pwm), 1);
        end
        push(4'd3, 5'd31);
        send(4'd3, 5'd31);
        wait_upd(20);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("duty31_pwm", 32'(pwm), 1);
        end

        // Reset while PENDING discards the pending configuration
        send(4'd2, 5'd1);
        check("mid_rdy_pending", 32'(cfg_rdy), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rdy", 32'(cfg_rdy), 1);
        check("mid_max", 32'(max), 15);
        check("mid_dty", 32'(dty), 0);
        check("mid_upd", 32'(upd), 0);
        for (int i = 0; i < 40; i++) begin
            tick();
            check("mid_no_upd", 32'(upd), 0);
            check("mid_max_run", 32'(max), 15);
        end

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
